// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter that grants bounded load bursts into one shared DATA_W register.
// Define ARB_LOCK_EN to add the lock input, which lets a granted lane exceed MAX_HOLD.
module dff_bank_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
`ifdef ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock,
`endif
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         q,
  output logic                      q_valid,
  output logic                      busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

  state_e                         state_q, state_d;
  logic [NUM_REQ-1:0]             gnt_q, gnt_d, ack_q, ack_d;
  logic [IDX_W-1:0]               gidx_q, gidx_d, ptr_q, ptr_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [DATA_W-1:0]              q_q, q_d;
  logic                           qv_q, qv_d;
  logic [NUM_REQ-1:0][DATA_W-1:0] lanes;
  logic [IDX_W-1:0]               win_idx;
  logic                           win_found, lock_cur, rel;
  int                             j;

  assign lanes = wr_data;

`ifdef ARB_LOCK_EN
  assign lock_cur = lock[gidx_q];
`else
  assign lock_cur = 1'b0;
`endif

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_q) + k) % NUM_REQ;
      if (!win_found && req[IDX_W'(j)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    q_d     = q_q;
    qv_d    = qv_q;
    rel     = 1'b0;
    case (state_q)
      IDLE, RELEASE: begin
        if (win_found) begin
          state_d = GRANT;
          gnt_d   = NUM_REQ'(1) << win_idx;
          gidx_d  = win_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (req[gidx_q]) begin
          q_d           = lanes[gidx_q];
          ack_d[gidx_q] = 1'b1;
          qv_d          = 1'b1;
          if (cnt_q != CNT_W'(MAX_HOLD)) cnt_d = cnt_q + 1'b1;
          // This load is the MAX_HOLD-th (counter saturates while locked).
          if (!lock_cur && cnt_q >= CNT_W'(MAX_HOLD - 1)) rel = 1'b1;
        end else begin
          rel = 1'b1;
        end
        if (rel) begin
          state_d = RELEASE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      q_q     <= '0;
      qv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      qv_q    <= qv_d;
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign q       = q_q;
  assign q_valid = qv_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Scenario bench for dff_bank_arbiter: per-cycle grant/busy tables plus a load scoreboard
// that expects each ack/q exactly one cycle after the bench schedules the load.
module tb_dff_bank_arbiter;
  logic        clk, reset;
  logic [3:0]  req, gnt, ack;
  logic [31:0] wr_data;
  logic [7:0]  q;
  logic        q_valid, busy;
`ifdef ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  dff_bank_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .wr_data(wr_data),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .ack(ack), .q(q), .q_valid(q_valid), .busy(busy)
  );

  typedef struct {int cyc; int idx; logic [7:0] d;} exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int   total = 0, bad = 0, cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard: a scheduled load must show up as ack + q in the following cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      e_mon = sb.pop_front();
      total++;
      if (ack !== (4'b1 << e_mon.idx) || q !== e_mon.d || q_valid !== 1'b1 || e_mon.cyc != cyc_cnt) begin
        bad++;
        $display("FAIL sb_load cyc=%0d ack=%b q=%h qv=%b want ack=%b q=%h qv=1 at cyc=%0d",
                 cyc_cnt, ack, q, q_valid, 4'b1 << e_mon.idx, e_mon.d, e_mon.cyc);
      end
    end else begin
      total++;
      if (ack !== 4'b0000) begin
        bad++;
        $display("FAIL sb_spurious_ack cyc=%0d ack=%b want 0000", cyc_cnt, ack);
      end
    end
  end

  task automatic set_lane(input int i, input logic [7:0] v);
    wr_data[i*8 +: 8] = v;
  endtask

  task automatic push(input int i, input logic [7:0] v);
    sb.push_back('{cyc_cnt + 1, i, v});
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1; req = 4'b0000;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({busy, gnt, ack, q, q_valid} !== 18'b0) begin
        bad++;
        $display("FAIL reset_outs c=%0d busy=%b gnt=%b ack=%b q=%h qv=%b want all 0", c, busy, gnt, ack, q, q_valid);
      end
      req = 4'($urandom);
    end
    reset = 1'b0;
    req   = 4'b0000;
  endtask

  task automatic test_basic();
    logic [4:0] exp_st [6] = '{5'b0_0000, 5'b1_0010, 5'b1_0010, 5'b1_0010, 5'b1_0000, 5'b0_0000};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if ({busy, gnt} !== exp_st[c]) begin
        bad++; $display("FAIL basic_st c=%0d got=%b want=%b", c, {busy, gnt}, exp_st[c]);
      end
      if (c >= 4) begin
        total++;
        if (q !== 8'h22) begin bad++; $display("FAIL basic_q_hold c=%0d got=%h want=22", c, q); end
      end
      case (c)
        0: begin req = 4'b0010; set_lane(1, 8'h11); end
        1: push(1, 8'h11);
        2: begin set_lane(1, 8'h22); push(1, 8'h22); end
        3: req = 4'b0000;
        default: ;
      endcase
    end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_st [11] = '{5'b0_0000, 5'b1_0001, 5'b1_0001, 5'b1_0000, 5'b1_0100, 5'b1_0100,
                                5'b1_0000, 5'b0_0000, 5'b1_0001, 5'b1_0000, 5'b0_0000};
    pulse_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      total++;
      if ({busy, gnt} !== exp_st[c]) begin
        bad++; $display("FAIL rr_st c=%0d got=%b want=%b", c, {busy, gnt}, exp_st[c]);
      end
      case (c)
        0: begin req = 4'b0101; set_lane(0, 8'hA0); set_lane(2, 8'hC2); end
        1: push(0, 8'hA0);
        2: req = 4'b0100;
        4: push(2, 8'hC2);
        5: req = 4'b0000;
        7: req = 4'b0101;
        8: req = 4'b0000;
        default: ;
      endcase
    end
  endtask

  task automatic test_max_hold();
    logic [4:0] exp_st [14];
    pulse_reset();
    for (int c = 0; c < 14; c++) begin
      if (c == 0 || c == 13)      exp_st[c] = 5'b0_0000;
      else if (c == 5 || c == 10 || c == 12) exp_st[c] = 5'b1_0000;
      else if (c == 11)           exp_st[c] = 5'b1_0001;
      else                        exp_st[c] = 5'b1_1000;
    end
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      total++;
      if ({busy, gnt} !== exp_st[c]) begin
        bad++; $display("FAIL hold_st c=%0d got=%b want=%b", c, {busy, gnt}, exp_st[c]);
      end
      if (c == 0) req = 4'b1000;
      if (c == 6) req = 4'b1001;
      if (c == 11) req = 4'b0000;
      if ((c >= 1 && c <= 4) || (c >= 6 && c <= 9)) begin
        set_lane(3, 8'h30 + 8'(c));
        push(3, 8'h30 + 8'(c));
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [4:0] exp_st [7] = '{5'b0_0000, 5'b1_0100, 5'b1_0100, 5'b0_0000, 5'b1_0001, 5'b1_0000, 5'b0_0000};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++;
      if ({busy, gnt} !== exp_st[c]) begin
        bad++; $display("FAIL midrst_st c=%0d got=%b want=%b", c, {busy, gnt}, exp_st[c]);
      end
      case (c)
        0: begin req = 4'b0100; set_lane(2, 8'h5A); end
        1: push(2, 8'h5A);
        2: begin set_lane(2, 8'h6B); reset = 1'b1; end
        3: begin
          total++;
          if ({ack, q, q_valid} !== 13'b0) begin
            bad++; $display("FAIL midrst_outs ack=%b q=%h qv=%b want 0", ack, q, q_valid);
          end
          reset = 1'b0;
          req   = 4'b1001;
        end
        4: req = 4'b0000;
        default: ;
      endcase
    end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [4:0] exp_st [16];
    pulse_reset();
    lock = 4'b0001;
    for (int c = 0; c < 16; c++) begin
      if (c == 0 || c == 15)      exp_st[c] = 5'b0_0000;
      else if (c <= 11)           exp_st[c] = 5'b1_0001;
      else if (c == 13)           exp_st[c] = 5'b1_0010;
      else                        exp_st[c] = 5'b1_0000;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      total++;
      if ({busy, gnt} !== exp_st[c]) begin
        bad++; $display("FAIL lock_st c=%0d got=%b want=%b", c, {busy, gnt}, exp_st[c]);
      end
      if (c == 0) req = 4'b0011;
      if (c >= 1 && c <= 10) begin
        set_lane(0, 8'h80 + 8'(c));
        push(0, 8'h80 + 8'(c));
      end
      if (c == 11) req = 4'b0010;
      if (c == 13) begin req = 4'b0000; lock = 4'b0000; end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clk     = 1'b0;
    reset   = 1'b1;
    req     = 4'($urandom);
    wr_data = '0;
`ifdef ARB_LOCK_EN
    lock    = 4'b0000;
`endif
    test_reset();
    test_basic();
    test_round_robin();
    test_max_hold();
    test_reset_mid_burst();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
